ram_burst_master: RTL and testbench

- Initiator-side controller for the single-port synchronous RAM block (CS/WRITE/READ strobes, registered read data).
- Accepts burst requests (start address, beat count, direction) on a valid/ready handshake.
- Write data streams in on valid/ready; read data streams out on a valid-only channel.
- Issues at most one RAM access per cycle, tracks the RAM's one-cycle read latency, and pulses done at burst end.

---
 rtl/ram_burst_master_if.sv | 38 +++
 rtl/ram_burst_master.sv | 131 +++++++++++++
 tb/tb_ram_burst_master.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_master_if.sv
// Burst request, write-stream, read-stream and RAM strobe bundle for ram_burst_master.
interface ram_burst_master_if #(
  parameter int ADR  = 10,
  parameter int DATA = 8,
  parameter int LEN  = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ADR-1:0]   req_addr;
  logic [LEN-1:0]   req_len;
  logic [DATA-1:0]  wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [DATA-1:0]  rd_data;
  logic             rd_valid;
  logic             done;
  logic             ram_cs;
  logic             ram_write;
  logic             ram_read;
  logic [ADR-1:0]   ram_addr;
  logic [DATA-1:0]  ram_din;
  logic [DATA-1:0]  ram_dout;

  // Controller side.
  modport master (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid, ram_dout,
    output req_ready, wr_ready, rd_data, rd_valid, done,
           ram_cs, ram_write, ram_read, ram_addr, ram_din
  );

  // Requester / RAM side.
  modport slave (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid, ram_dout,
    input  req_ready, wr_ready, rd_data, rd_valid, done,
           ram_cs, ram_write, ram_read, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: one access per cycle,
// one-cycle read latency tracked, done pulse at burst end.
module ram_burst_master #(
  parameter int ADR  = 10,
  parameter int DATA = 8,
  parameter int MS   = 1024,
  parameter int LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_burst_master_if.master    bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WLAST} state_t;

  state_t          r_state,    w_state_n;
  logic [LEN-1:0]  r_cnt,      w_cnt_n;
  logic [ADR-1:0]  r_addr,     w_addr_n;
  logic [ADR-1:0]  r_ram_addr, w_ram_addr_n;
  logic [DATA-1:0] r_din,      w_din_n;
  logic            r_cs,       w_cs_n;
  logic            r_write,    w_write_n;
  logic            r_read,     w_read_n;
  logic            r_done,     w_done_n;
  logic            r_rd_valid;
  logic [ADR-1:0]  w_addr_inc;
  logic            w_req_ready;

  // Address register always points at the beat being (or about to be) strobed.
  assign w_addr_inc  = (r_addr == ADR'(MS - 1)) ? '0 : r_addr + ADR'(1);
  assign w_req_ready = (r_state == S_IDLE);

  assign bus.req_ready = w_req_ready;
  assign bus.wr_ready  = (r_state == S_WR);
  assign bus.ram_cs    = r_cs;
  assign bus.ram_write = r_write;
  assign bus.ram_read  = r_read;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_din   = r_din;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = bus.ram_dout;
  assign bus.done      = r_done;

  // Next-state and next-strobe decode; strobes and done default low each cycle.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_addr_n     = r_addr;
    w_ram_addr_n = r_ram_addr;
    w_din_n      = r_din;
    w_cs_n       = 1'b0;
    w_write_n    = 1'b0;
    w_read_n     = 1'b0;
    w_done_n     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid && w_req_ready) begin
          w_addr_n = bus.req_addr;
          w_cnt_n  = bus.req_len;
          if (bus.req_write) begin
            w_state_n = S_WR;
          end else begin
            // First read strobe goes out on the accept edge.
            w_state_n    = S_RD;
            w_cs_n       = 1'b1;
            w_read_n     = 1'b1;
            w_ram_addr_n = bus.req_addr;
          end
        end
      end
      S_RD: begin
        if (r_cnt == '0) begin
          // Last strobe already issued; its data returns with this done.
          w_state_n = S_IDLE;
          w_done_n  = 1'b1;
        end else begin
          w_addr_n     = w_addr_inc;
          w_cnt_n      = r_cnt - LEN'(1);
          w_cs_n       = 1'b1;
          w_read_n     = 1'b1;
          w_ram_addr_n = w_addr_inc;
        end
      end
      S_WR: begin
        // No handshake means a stall: no strobe, address holds.
        if (bus.wr_valid) begin
          w_cs_n       = 1'b1;
          w_write_n    = 1'b1;
          w_ram_addr_n = r_addr;
          w_din_n      = bus.wr_data;
          w_addr_n     = w_addr_inc;
          if (r_cnt == '0) w_state_n = S_WLAST;
          else             w_cnt_n   = r_cnt - LEN'(1);
        end
      end
      S_WLAST: begin
        w_state_n = S_IDLE;
        w_done_n  = 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; rd_valid is ram_read delayed one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_ram_addr <= '0;
      r_din      <= '0;
      r_cs       <= 1'b0;
      r_write    <= 1'b0;
      r_read     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_addr     <= w_addr_n;
      r_ram_addr <= w_ram_addr_n;
      r_din      <= w_din_n;
      r_cs       <= w_cs_n;
      r_write    <= w_write_n;
      r_read     <= w_read_n;
      r_done     <= w_done_n;
      r_rd_valid <= r_read;
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a RAM model and strobe/read-data scoreboards.
module tb_ram_burst_master;
  localparam int ADR = 10, DATA = 8, MS = 1024, LEN = 8;

  typedef struct {
    logic            w;
    logic [ADR-1:0]  a;
    logic [DATA-1:0] d;
  } strb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0, errors = 0, cyc = 0, n_done = 0;

  strb_t           sq[$];
  logic [DATA-1:0] rq[$];
  int              strb_cyc[$], rdv_cyc[$], dn_cyc[$];
  logic [DATA-1:0] gold [MS];
  logic [DATA-1:0] mem  [MS];
  logic [DATA-1:0] ram_q = '0;
  logic [ADR-1:0]  waddr = '0;

  ram_burst_master_if #(.ADR(ADR), .DATA(DATA), .LEN(LEN)) bus();

  ram_burst_master #(.ADR(ADR), .DATA(DATA), .MS(MS), .LEN(LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: write on CS&WRITE, registered read data on CS&READ.
  assign bus.ram_dout = ram_q;
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
    if (bus.ram_cs && bus.ram_read)  ram_q <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADR-1:0] nxt(input logic [ADR-1:0] a);
    return (32'(a) == MS - 1) ? '0 : a + ADR'(1);
  endfunction

  // Monitor: strobe legality, strobe and read-data scoreboards, done timing.
  always @(negedge clk) begin
    chk("no_rw_overlap", 32'(bus.ram_read & bus.ram_write), 0);
    chk("cs_eq_strobe", 32'(bus.ram_cs), 32'(bus.ram_read | bus.ram_write));
    if (bus.ram_cs) begin
      strb_t e;
      strb_cyc.push_back(cyc);
      chk("strobe_expected", 32'(sq.size() > 0), 1);
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("strobe_dir", 32'(bus.ram_write), 32'(e.w));
        chk("strobe_addr", 32'(bus.ram_addr), 32'(e.a));
        if (e.w) chk("strobe_din", 32'(bus.ram_din), 32'(e.d));
      end
    end
    if (bus.rd_valid) begin
      rdv_cyc.push_back(cyc);
      chk("rd_expected", 32'(rq.size() > 0), 1);
      if (rq.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(rq.pop_front()));
    end
    if (bus.done) begin
      dn_cyc.push_back(cyc);
      n_done++;
    end
  end

  // Offer a request until accepted; read expectations are queued once accepted.
  task automatic req(input logic w, input logic [ADR-1:0] a, input logic [LEN-1:0] l);
    int t = 0;
    logic [ADR-1:0] ad;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_len = l;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
    chk("req_accept_timeout", 32'(t < 200), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (w) waddr = a;
    else begin
      ad = a;
      for (int i = 0; i <= int'(l); i++) begin
        sq.push_back('{1'b0, ad, '0});
        rq.push_back(gold[ad]);
        ad = nxt(ad);
      end
    end
  endtask

  // One write beat, optionally preceded by stall cycles with wr_valid low.
  task automatic wbeat(input logic [DATA-1:0] d, input int stall);
    int t = 0;
    if (stall > 0) begin
      bus.wr_valid = 1'b0;
      repeat (stall) begin
        @(posedge clk); @(negedge clk);
        chk("stall_no_cs", 32'(bus.ram_cs), 0);
      end
    end
    bus.wr_valid = 1'b1; bus.wr_data = d;
    if (stall == 0) @(negedge clk);
    while (!bus.wr_ready && t < 200) begin @(negedge clk); t++; end
    chk("wr_ready_timeout", 32'(t < 200), 1);
    @(posedge clk); #1;
    sq.push_back('{1'b1, waddr, d});
    gold[waddr] = d;
    waddr = nxt(waddr);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 300) begin @(negedge clk); #1; t++; end
    chk("done_timeout", 32'(n_done >= target), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 1'b0;  bus.wr_data = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_wr_ready",  32'(bus.wr_ready), 0);
    chk("rst_ram_cs",    32'(bus.ram_cs), 0);
    chk("rst_ram_write", 32'(bus.ram_write), 0);
    chk("rst_ram_read",  32'(bus.ram_read), 0);
    chk("rst_ram_addr",  32'(bus.ram_addr), 0);
    chk("rst_ram_din",   32'(bus.ram_din), 0);
    chk("rst_rd_valid",  32'(bus.rd_valid), 0);
    chk("rst_done",      32'(bus.done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write burst 0x010, 4 beats, wr_valid held high.
    nd = n_done; strb_cyc.delete(); dn_cyc.delete();
    req(1'b1, 10'h010, 8'd3);
    wbeat(8'hA0, 0); wbeat(8'hA1, 0); wbeat(8'hA2, 0); wbeat(8'hA3, 0);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("wlast_wr_ready", 32'(bus.wr_ready), 0);
    chk("wlast_ram_write", 32'(bus.ram_write), 1);
    wait_done(nd + 1);
    @(negedge clk);
    chk("done_single_pulse", 32'(bus.done), 0);
    chk("wr1_strobes", strb_cyc.size(), 4);
    chk("wr1_contiguous", strb_cyc[3] - strb_cyc[0], 3);
    chk("wr1_done_cycle", dn_cyc[0], strb_cyc[3] + 1);
    @(posedge clk); #1;

    // Read back the same range.
    nd = n_done; strb_cyc.delete(); rdv_cyc.delete(); dn_cyc.delete();
    req(1'b0, 10'h010, 8'd3);
    wait_done(nd + 1);
    chk("rd1_strobes", strb_cyc.size(), 4);
    chk("rd1_contiguous", strb_cyc[3] - strb_cyc[0], 3);
    chk("rd1_valid_count", rdv_cyc.size(), 4);
    chk("rd1_first_latency", rdv_cyc[0], strb_cyc[0] + 1);
    chk("rd1_last_latency", rdv_cyc[3], strb_cyc[3] + 1);
    chk("rd1_done_with_last", dn_cyc[0], rdv_cyc[3]);
    chk("rd1_rq_drained", rq.size(), 0);

    // Wrap-around write then read-back.
    nd = n_done; strb_cyc.delete();
    req(1'b1, 10'h3FE, 8'd3);
    wbeat(8'h11, 0); wbeat(8'h12, 0); wbeat(8'h13, 0); wbeat(8'h14, 0);
    bus.wr_valid = 1'b0;
    wait_done(nd + 1);
    chk("wrap_wr_strobes", strb_cyc.size(), 4);
    nd = n_done; rdv_cyc.delete();
    req(1'b0, 10'h3FE, 8'd3);
    wait_done(nd + 1);
    chk("wrap_rd_count", rdv_cyc.size(), 4);
    chk("wrap_rq_drained", rq.size(), 0);

    // Stalled write: beats 1 and 2 each wait 2 cycles.
    nd = n_done; strb_cyc.delete();
    req(1'b1, 10'h100, 8'd3);
    wbeat(8'h21, 0); wbeat(8'h22, 2); wbeat(8'h23, 2); wbeat(8'h24, 0);
    bus.wr_valid = 1'b0;
    wait_done(nd + 1);
    chk("stall_strobes", strb_cyc.size(), 4);
    chk("stall_span", strb_cyc[3] - strb_cyc[0], 7);

    // Back-to-back: read held pending during a write burst.
    nd = n_done; strb_cyc.delete(); dn_cyc.delete(); rdv_cyc.delete();
    req(1'b1, 10'h200, 8'd1);
    fork
      begin wbeat(8'h31, 0); wbeat(8'h32, 0); bus.wr_valid = 1'b0; end
      req(1'b0, 10'h200, 8'd1);
    join
    wait_done(nd + 2);
    chk("b2b_strobes", strb_cyc.size(), 4);
    chk("b2b_wr_done", dn_cyc[0], strb_cyc[1] + 1);
    chk("b2b_rd_start", strb_cyc[2], dn_cyc[0] + 1);
    chk("b2b_rd_count", rdv_cyc.size(), 2);

    // Reset during a read burst, after the 2nd strobe.
    nd = n_done;
    req(1'b0, 10'h010, 8'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ram_cs",    32'(bus.ram_cs), 0);
    chk("mid_rst_ram_read",  32'(bus.ram_read), 0);
    chk("mid_rst_rd_valid",  32'(bus.rd_valid), 0);
    chk("mid_rst_done",      32'(bus.done), 0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
    chk("mid_rst_ram_addr",  32'(bus.ram_addr), 0);
    #1;
    chk("mid_rst_strobes_left", sq.size(), 2);
    chk("mid_rst_beats_left", rq.size(), 3);
    chk("mid_rst_no_done", n_done, nd);
    sq.delete(); rq.delete();
    @(posedge clk); #1;
    rdv_cyc.delete();
    req(1'b0, 10'h012, 8'd0);
    wait_done(nd + 1);
    chk("post_rst_rd_count", rdv_cyc.size(), 1);
    chk("post_rst_sq_drained", sq.size(), 0);
    chk("post_rst_rq_drained", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
